// File: rtl/goal_referee.sv
// goal_referee: match referee FSM for a two-player ball game, clocked once per video frame.
//
// States: IDLE -> PLAY -> GOAL -> RESPAWN -> PLAY ... -> OVER -> IDLE.
//
// Ports:
//   Reset            async active-high reset
//   frame_clk        one rising edge per video frame
//   keycode[7:0]     USB keycode; 8'h28 (Enter) starts or restarts a match
//   BallX/Y/S        ball centre and half-size
//   LGoalX/LGoalSX   left goal centre X and half-width
//   RGoalX/RGoalSX   right goal centre X and half-width
//   GoalY/GoalSY     shared goal centre Y and half-height
//   AllowInput       high only in PLAY
//   BallReset        respawn request to the ball block (IDLE, RESPAWN, OVER)
//   GameOver         high only in OVER
//   ScoreP1/ScoreP2  goal counts, saturating at 15
//   TimeLeft         match seconds remaining
//   Winner           00 none, 01 P1, 10 P2, 11 draw; meaningful in OVER
//
// Build option: define REFEREE_TIMER_EN to include the match timer. Without it the
// timer is removed, TimeLeft reads 0 and a match ends only on score.

module goal_referee #(
  parameter int unsigned WIN_SCORE        = 5,
  parameter int unsigned FRAMES_PER_SEC   = 60,
  parameter int unsigned MATCH_SECS       = 90,
  parameter int unsigned CELEBRATE_FRAMES = 120
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] BallS,
  input  logic [9:0] LGoalX,
  input  logic [9:0] LGoalSX,
  input  logic [9:0] RGoalX,
  input  logic [9:0] RGoalSX,
  input  logic [9:0] GoalY,
  input  logic [9:0] GoalSY,
  output logic       AllowInput,
  output logic       BallReset,
  output logic       GameOver,
  output logic [3:0] ScoreP1,
  output logic [3:0] ScoreP2,
  output logic [6:0] TimeLeft,
  output logic [1:0] Winner
);

  typedef enum logic [2:0] {StIdle, StPlay, StGoal, StRespawn, StOver} state_e;

  localparam int unsigned CelW = (CELEBRATE_FRAMES > 1) ? $clog2(CELEBRATE_FRAMES) : 1;
  localparam logic [CelW-1:0] CelLast = CelW'(CELEBRATE_FRAMES - 1);

  function automatic logic [10:0] sat_sub(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? ({1'b0, a} - {1'b0, b}) : 11'd0;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  state_e          state_q, state_d;
  logic            key_prev_q, key_prev_d;
  logic [3:0]      score_p1_q, score_p1_d;
  logic [3:0]      score_p2_q, score_p2_d;
  logic [CelW-1:0] cel_q, cel_d;
  logic [1:0]      winner_q, winner_d;
  logic            allow_input_q, allow_input_d;
  logic            ball_reset_q, ball_reset_d;
  logic            game_over_q, game_over_d;

  logic key_hit, start_evt;
  logic y_ok, left_goal, right_goal, win_reached;
  logic time_zero;

  assign key_hit   = (keycode == 8'h28);
  // Only the press edge counts, so a held Enter cannot bounce OVER->IDLE->PLAY.
  assign start_evt = key_hit & ~key_prev_q;

  assign y_ok       = sat_sub(BallY, BallS) >= sat_sub(GoalY, GoalSY);
  assign left_goal  = y_ok && (({1'b0, BallX} + {1'b0, BallS}) <= ({1'b0, LGoalX} + {1'b0, LGoalSX}));
  assign right_goal = y_ok && (sat_sub(BallX, BallS) >= sat_sub(RGoalX, RGoalSX));

  assign win_reached = (32'(score_p1_q) >= WIN_SCORE) || (32'(score_p2_q) >= WIN_SCORE);

`ifdef REFEREE_TIMER_EN
  localparam int unsigned FcW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FcW-1:0] FcLast   = FcW'(FRAMES_PER_SEC - 1);
  localparam logic [6:0]     MatchInit = 7'(MATCH_SECS);

  logic [FcW-1:0] frame_cnt_q, frame_cnt_d;
  logic [6:0]     time_left_q, time_left_d;

  assign time_zero = (time_left_q == 7'd0);
  assign TimeLeft  = time_left_q;

  // The timer only advances in PLAY, so it stays frozen through GOAL and RESPAWN.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    time_left_d = time_left_q;
    if (state_q == StIdle && start_evt) begin
      frame_cnt_d = '0;
      time_left_d = MatchInit;
    end else if (state_q == StPlay) begin
      if (frame_cnt_q == FcLast) begin
        frame_cnt_d = '0;
        if (!time_zero) time_left_d = time_left_q - 7'd1;
      end else begin
        frame_cnt_d = frame_cnt_q + FcW'(1);
      end
    end else if (state_q == StRespawn) begin
      frame_cnt_d = '0;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      frame_cnt_q <= '0;
      time_left_q <= MatchInit;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      time_left_q <= time_left_d;
    end
  end
`else
  logic unused_timer_cfg;
  assign unused_timer_cfg = ^{FRAMES_PER_SEC, MATCH_SECS};
  assign time_zero        = 1'b0;
  assign TimeLeft         = 7'd0;
`endif

  always_comb begin
    state_d    = state_q;
    key_prev_d = key_hit;
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
    cel_d      = cel_q;

    unique case (state_q)
      StIdle: begin
        if (start_evt) begin
          state_d    = StPlay;
          score_p1_d = 4'd0;
          score_p2_d = 4'd0;
        end
      end
      StPlay: begin
        // A goal on the final-second edge is still scored before the match ends.
        if (left_goal) begin
          score_p2_d = sat_inc(score_p2_q);
          cel_d      = '0;
          state_d    = StGoal;
        end else if (right_goal) begin
          score_p1_d = sat_inc(score_p1_q);
          cel_d      = '0;
          state_d    = StGoal;
        end else if (time_zero) begin
          state_d = StOver;
        end
      end
      StGoal: begin
        if (cel_q == CelLast) begin
          state_d = (win_reached || time_zero) ? StOver : StRespawn;
        end else begin
          cel_d = cel_q + CelW'(1);
        end
      end
      StRespawn: state_d = StPlay;
      StOver: begin
        if (start_evt) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    winner_d = 2'b00;
    if (state_d == StOver) begin
      if (score_p1_d > score_p2_d)      winner_d = 2'b01;
      else if (score_p2_d > score_p1_d) winner_d = 2'b10;
      else                              winner_d = 2'b11;
    end

    // Outputs are registered from the next state so they line up with state_q.
    allow_input_d = (state_d == StPlay);
    game_over_d   = (state_d == StOver);
    ball_reset_d  = (state_d == StIdle) || (state_d == StRespawn) || (state_d == StOver);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= StIdle;
      key_prev_q    <= 1'b0;
      score_p1_q    <= 4'd0;
      score_p2_q    <= 4'd0;
      cel_q         <= '0;
      winner_q      <= 2'b00;
      allow_input_q <= 1'b0;
      ball_reset_q  <= 1'b1;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_prev_q    <= key_prev_d;
      score_p1_q    <= score_p1_d;
      score_p2_q    <= score_p2_d;
      cel_q         <= cel_d;
      winner_q      <= winner_d;
      allow_input_q <= allow_input_d;
      ball_reset_q  <= ball_reset_d;
      game_over_q   <= game_over_d;
    end
  end

  assign AllowInput = allow_input_q;
  assign BallReset  = ball_reset_q;
  assign GameOver   = game_over_q;
  assign ScoreP1    = score_p1_q;
  assign ScoreP2    = score_p2_q;
  assign Winner     = winner_q;

endmodule
